multicycle_control: RTL and testbench

Multicycle control FSM for the 16-bit processor. It sequences the shared ALU, memory port, register file and PC through fetch, decode, execute, memory and writeback. It drives the ALU's 3-bit `control` input and all datapath mux selects and write enables. It handles the memory ready handshake with a bounded wait.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/mem_wait_timer.sv | 18 +
 rtl/multicycle_control.sv | 139 +++++++++++++
 tb/tb_multicycle_control.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, opcode, ALU and mux-select encodings for the multicycle controller
package cpu_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
  } state_t;
  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_J    = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SL  = 3'd4;
  localparam logic [2:0] ALU_SR  = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  function automatic state_t decode_next(input logic [3:0] op);
    case (op)
      OP_R:          return S_EXEC_R;
      OP_ADDI:       return S_EXEC_I;
      OP_LW, OP_SW:  return S_MEM_ADDR;
      OP_BEQ, OP_BNE: return S_BRANCH;
      OP_J:          return S_JUMP;
      default:       return S_HALT;
    endcase
  endfunction
  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_J) || (op == OP_HALT);
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory wait cycles and flags the final allowed one
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);
  logic [7:0] r_count;
  always_ff @(posedge clock) begin
    if (reset || clear) r_count <= 8'd0;
    else if (count_en) r_count <= r_count + 8'd1;
  end
  assign expired = count_en && (r_count == LAST);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequences fetch/decode/execute/memory/writeback for the 16-bit multicycle CPU
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       halted,
  output logic       fault
);
  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op;
  logic       r_fault;
  logic       w_wait;
  logic       w_count_en;
  logic       w_expired;
  logic       w_fault_set;
  assign w_wait     = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_count_en = w_wait && !mem_ready;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (!w_count_en),
    .count_en (w_count_en),
    .expired  (w_expired)
  );
  assign w_fault_set = w_expired
                    || ((r_state == S_DECODE) && !is_legal(opcode))
                    || ((r_state == S_EXEC_R) && (funct == 3'd7));
  always_comb begin
    w_next = S_HALT;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : (w_expired ? S_HALT : S_FETCH);
      S_DECODE:   w_next = decode_next(opcode);
      S_EXEC_R:   w_next = (funct == 3'd7) ? S_HALT : S_WB_R;
      S_EXEC_I:   w_next = S_WB_I;
      S_MEM_ADDR: w_next = (r_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = mem_ready ? S_WB_MEM : (w_expired ? S_HALT : S_MEM_RD);
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : (w_expired ? S_HALT : S_MEM_WR);
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: w_next = S_FETCH;
      default:    w_next = S_HALT;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_fault <= 1'b0;
      r_op    <= OP_R;
    end else begin
      r_state <= w_next;
      r_fault <= r_fault || w_fault_set;
      if (r_state == S_DECODE) r_op <= opcode;
    end
  end
  always_comb begin
    alu_control = ALU_AND;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    pc_write    = 1'b0;
    pc_source   = PCSRC_ALU;
    ir_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = SRCB_TWO;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
      end
      S_DECODE: begin
        alu_src_b   = SRCB_IMM_SH;
        alu_control = ALU_ADD;
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_control = funct;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_WB_I: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_source   = PCSRC_ALUOUT;
        pc_write    = (r_op == OP_BNE) ? !zero : zero;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end
  assign halted = (r_state == S_HALT);
  assign fault  = r_fault;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction streams checked against a phase-level behavioural model
module tb_multicycle_control;
  localparam int TO = 4;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic [2:0] funct = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       halted;
  logic       fault;
  int         n_chk = 0;
  int         n_pass = 0;
  bit         m_fault = 1'b0;
  multicycle_control #(.MEM_TIMEOUT(TO)) dut (
    .clock       (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .alu_control (alu_control),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_write    (pc_write),
    .pc_source   (pc_source),
    .ir_write    (ir_write),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .halted      (halted),
    .fault       (fault)
  );
  always #5 clk = ~clk;
  logic [17:0] w_obs;
  assign w_obs = {alu_control, alu_src_a, alu_src_b, pc_write, pc_source, ir_write, iord,
                  mem_read, mem_write, reg_write, reg_dst, mem_to_reg, halted, fault};
  function automatic logic [17:0] ov(input logic [2:0] ac, input logic sa, input logic [1:0] sb,
                                     input logic pw, input logic [1:0] ps, input logic irw,
                                     input logic io, input logic mr, input logic mw, input logic rw,
                                     input logic rd, input logic m2r, input logic h, input logic f);
    return {ac, sa, sb, pw, ps, irw, io, mr, mw, rw, rd, m2r, h, f};
  endfunction
  function automatic logic [17:0] v_mem(input int kind, input logic r);
    if (kind == 0) return ov(3'd2, 0, 2'b01, r, 2'b00, r, 0, 1, 0, 0, 0, 0, 0, 0);
    if (kind == 1) return ov(3'd0, 0, 2'b00, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    return ov(3'd0, 0, 2'b00, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] v_halt(input logic f);
    return ov(3'd0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, f);
  endfunction
  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
  endtask
  task automatic cyc(input string tag, input logic rdy, input logic z, input logic [17:0] exp);
    mem_ready = rdy;
    zero = z;
    @(negedge clk);
    check(tag, w_obs, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_fault = 1'b0;
  endtask
  task automatic mem_wait(input string tag, input int kind, input int waits, output bit to);
    for (int i = 0; i <= waits && i < TO; i++) cyc(tag, i == waits, 1'($urandom), v_mem(kind, i == waits));
    to = (waits >= TO);
  endtask
  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      opcode = 4'($urandom);
      funct = 3'($urandom);
      cyc("halt", 1'($urandom), 1'($urandom), v_halt(m_fault));
    end
  endtask
  task automatic run_instr(input logic [3:0] op, input logic [2:0] fn, input int wf, input int wm,
                           input logic z, output bit hlt);
    bit to;
    hlt = 1'b0;
    opcode = op;
    funct = fn;
    mem_wait("fetch", 0, wf, to);
    if (to) begin
      m_fault = 1'b1;
      hlt = 1'b1;
      return;
    end
    cyc("decode", 1'($urandom), 1'($urandom), ov(3'd2, 0, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    case (op)
      4'h0: begin
        cyc("exec_r", 1'($urandom), 1'($urandom), ov(fn, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (fn == 3'd7) begin
          m_fault = 1'b1;
          hlt = 1'b1;
          return;
        end
        cyc("wb_r", 1'($urandom), 1'($urandom), ov(3'd0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      end
      4'h1: begin
        cyc("exec_i", 1'($urandom), 1'($urandom), ov(3'd2, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("wb_i", 1'($urandom), 1'($urandom), ov(3'd0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
      4'h2, 4'h3: begin
        cyc("mem_addr", 1'($urandom), 1'($urandom), ov(3'd2, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        mem_wait(op == 4'h2 ? "mem_rd" : "mem_wr", op == 4'h2 ? 1 : 2, wm, to);
        if (to) begin
          m_fault = 1'b1;
          hlt = 1'b1;
          return;
        end
        if (op == 4'h2)
          cyc("wb_mem", 1'($urandom), 1'($urandom), ov(3'd0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      end
      4'h4, 4'h5:
        cyc("branch", 1'($urandom), z, ov(3'd3, 1, 2'b00, op == 4'h4 ? z : !z, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      4'h6: cyc("jump", 1'($urandom), 1'($urandom), ov(3'd0, 0, 2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      4'hF: hlt = 1'b1;
      default: begin
        m_fault = 1'b1;
        hlt = 1'b1;
      end
    endcase
  endtask
  initial begin
    bit h;
    logic [3:0] op;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("reset_fetch", 1'b0, 1'b0, v_mem(0, 1'b0));
    run_instr(4'h0, 3'd2, 0, 0, 1'b0, h);
    cyc("r_then_fetch", 1'b0, 1'b0, v_mem(0, 1'b0));
    run_instr(4'h2, 3'd0, 0, 3, 1'b0, h);
    run_instr(4'h4, 3'd0, 0, 0, 1'b1, h);
    run_instr(4'h4, 3'd0, 0, 0, 1'b0, h);
    run_instr(4'h5, 3'd0, 0, 0, 1'b1, h);
    run_instr(4'h5, 3'd0, 0, 0, 1'b0, h);
    run_instr(4'h3, 3'd0, 0, 1, 1'b0, h);
    run_instr(4'h6, 3'd0, 0, 0, 1'b0, h);
    run_instr(4'h1, 3'd0, 3, 0, 1'b0, h);
    run_instr(4'h0, 3'd0, TO, 0, 1'b0, h);
    halt_hold(3);
    do_reset();
    run_instr(4'h1, 3'd0, TO - 1, 0, 1'b0, h);
    run_instr(4'h9, 3'd0, 0, 0, 1'b0, h);
    halt_hold(20);
    do_reset();
    run_instr(4'h0, 3'd7, 0, 0, 1'b0, h);
    halt_hold(20);
    do_reset();
    run_instr(4'hF, 3'd0, 0, 0, 1'b0, h);
    halt_hold(3);
    do_reset();
    opcode = 4'h3;
    cyc("sw_fetch", 1'b1, 1'b0, v_mem(0, 1'b1));
    cyc("sw_decode", 1'b0, 1'b0, ov(3'd2, 0, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw_addr", 1'b0, 1'b0, ov(3'd2, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw_wait", 1'b0, 1'b0, v_mem(2, 1'b0));
    do_reset();
    cyc("mid_reset", 1'b0, 1'b0, v_mem(0, 1'b0));
    run_instr(4'h0, 3'd1, 2, 0, 1'b0, h);
    for (int n = 0; n < 250; n++) begin
      op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom);
      run_instr(op, 3'($urandom), ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1),
                ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1),
                1'($urandom), h);
      if (h) begin
        halt_hold(3);
        do_reset();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
